// File: rtl/me_pkg.sv
// ---------------------------------------------------------------------------
// me_pkg
// Shared geometry for the motion-estimation reference path. The row
// separator and the row packer both import this so that pixel, row and
// block widths can never disagree between the two ends of the path.
//
// Contents
//   PIXEL  bits per pixel
//   COLS   pixels per reference-window row
//   ROWS   rows per packed block
//   ROW_W  bits per row   (COLS*PIXEL)
//   BLK_W  bits per block (ROWS*ROW_W)
//   CNT_W  width of a row index within a block
//   row_lsb() bit offset of row k inside a packed block
// ---------------------------------------------------------------------------
package me_pkg;

  localparam int PIXEL = 8;
  localparam int COLS  = 32;
  localparam int ROWS  = 8;
  localparam int ROW_W = COLS * PIXEL;
  localparam int BLK_W = ROWS * ROW_W;
  localparam int CNT_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  // Row k of a packed block occupies [k*ROW_W +: ROW_W]; row 0 is the LSBs.
  function automatic int row_lsb(input int k);
    return k * ROW_W;
  endfunction

endpackage

// File: rtl/row_pack_asm.sv
// ---------------------------------------------------------------------------
// row_pack_asm
// Assembly side of the row packer: the block-sized assembly buffer, the row
// counter that selects where the next accepted row lands, and the
// start-of-frame resynchronisation that raises sync_err.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   i_accept       in   a row beat is accepted on this edge
//   i_sof          in   accepted row is row 0 of a new block
//   i_row          in   row data, pixel c at [c*PIXEL +: PIXEL]
//   o_last         out  this accepted row completes a block
//   o_blk_buf      out  assembly buffer as currently registered
//   o_blk_merged   out  assembly buffer with i_row already placed at its
//                       write index (what the buffer becomes after the edge)
//   o_sync_err     out  one-cycle pulse: sof arrived with a partial block
// ---------------------------------------------------------------------------
module row_pack_asm
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_accept,
  input  logic             i_sof,
  input  logic [ROW_W-1:0] i_row,
  output logic             o_last,
  output logic [BLK_W-1:0] o_blk_buf,
  output logic [BLK_W-1:0] o_blk_merged,
  output logic             o_sync_err
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ROWS - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [BLK_W-1:0] r_buf;
  logic             r_sync_err;

  logic [CNT_W-1:0] w_wr_idx;
  logic [CNT_W-1:0] w_cnt_next;
  logic [BLK_W-1:0] w_merged;

  // A start-of-frame row always restarts the block at row 0; any rows that
  // were already collected are simply overwritten later, never emitted,
  // because a block is only released once all ROWS slots are rewritten.
  always_comb begin
    w_wr_idx   = i_sof ? '0 : r_cnt;
    w_cnt_next = (w_wr_idx == LAST_IDX) ? '0 : w_wr_idx + CNT_W'(1);
  end

  // The merged view lets the top load a completed block into the output
  // register on the same edge its last row arrives (1-cycle latency).
  always_comb begin
    w_merged = r_buf;
    w_merged[row_lsb(int'(w_wr_idx)) +: ROW_W] = i_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_buf      <= '0;
      r_sync_err <= 1'b0;
    end else begin
      r_sync_err <= i_accept && i_sof && (r_cnt != '0);
      if (i_accept) begin
        r_buf <= w_merged;
        r_cnt <= w_cnt_next;
      end
    end
  end

  // A sof row can never complete a block: it is row 0 by definition.
  assign o_last       = i_accept && !i_sof && (r_cnt == LAST_IDX);
  assign o_blk_buf    = r_buf;
  assign o_blk_merged = w_merged;
  assign o_sync_err   = r_sync_err;

endmodule

// File: rtl/row_pack.sv
// ---------------------------------------------------------------------------
// row_pack
// Packs ROWS consecutive reference-window rows into one block word for the
// ME array (inverse of the row separator). Double-buffered: while the output
// register holds a block for the consumer, the next block assembles in
// row_pack_asm. Only when both are full does the row input stall.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   row beat valid
//   in_ready   out  row beat accepted when in_valid & in_ready
//   in_sof     in   first row of a block (qualified by an accepted beat)
//   in_row     in   one row, pixel c at [c*PIXEL +: PIXEL]
//   out_valid  out  packed block available
//   out_ready  in   consumer takes block when out_valid & out_ready
//   ref_ou     out  packed block, row k at [k*ROW_W +: ROW_W]
//   sync_err   out  one-cycle pulse: sof accepted while a block was partial
// ---------------------------------------------------------------------------
module row_pack
  import me_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sof,
  input  logic [ROW_W-1:0] in_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLK_W-1:0] ref_ou,
  output logic             sync_err
);

  logic             r_out_valid;
  logic [BLK_W-1:0] r_ref_ou;
  logic             r_asm_full;

  logic             w_accept;
  logic             w_drain;
  logic             w_out_free;
  logic             w_last;
  logic [BLK_W-1:0] w_blk_buf;
  logic [BLK_W-1:0] w_blk_merged;

  assign in_ready   = !r_asm_full;
  assign w_accept   = in_valid && in_ready;
  assign w_drain    = r_out_valid && out_ready;
  assign w_out_free = !r_out_valid || w_drain;

  row_pack_asm u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_accept     (w_accept),
    .i_sof        (in_sof),
    .i_row        (in_row),
    .o_last       (w_last),
    .o_blk_buf    (w_blk_buf),
    .o_blk_merged (w_blk_merged),
    .o_sync_err   (sync_err)
  );

  // Output register and the second buffer slot. asm_full means a finished
  // block is parked in the assembly buffer; it cannot coexist with a new
  // completion because in_ready is low while it is set. A drain on the same
  // edge as a transfer-in keeps out_valid high, giving back-to-back blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_ref_ou    <= '0;
      r_asm_full  <= 1'b0;
    end else if (r_asm_full && w_drain) begin
      r_ref_ou    <= w_blk_buf;
      r_out_valid <= 1'b1;
      r_asm_full  <= 1'b0;
    end else if (w_last && w_out_free) begin
      r_ref_ou    <= w_blk_merged;
      r_out_valid <= 1'b1;
    end else if (w_last) begin
      r_asm_full  <= 1'b1;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign ref_ou    = r_ref_ou;

endmodule
